text_writer: RTL

- Writer side of the 32x24 character video RAM that the VGA text adapter scans.
- Accepts a byte stream (e.g. from a UART receiver) over a valid/ready handshake.
- Interprets printable codes and a small set of control codes, maintains a cursor, and writes character codes into the RAM's write/read port.
- Handles line wrap, clear-screen and (optionally) scroll-up by RAM read-modify-write.

---
 rtl/text_writer.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/text_writer.sv
// Writer side of the 32x24 text video RAM: byte stream in, cursor-tracked character writes out.
// Build option: define TEXT_WRITER_SCROLL_EN to scroll the screen on a new line at the bottom row.
//
// state     | meaning
// IDLE      | waiting for a byte, in_ready high
// PUT       | writing one printable character at the cursor
// CLEAR     | filling the visible area with CLEAR_CHAR
// SCR_RD    | scroll: reading the cell one row below
// SCR_WR    | scroll: writing the read cell one row up
// SCR_BLANK | scroll: blanking the bottom row
module text_writer #(
   parameter int          COLS       = 32,
   parameter int          ROWS       = 24,
   parameter int          ADDR_W     = 10,
   parameter logic [7:0]  CLEAR_CHAR = 8'h20
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [7:0]        ram_wdata,
   output logic              ram_we,
   input  logic [7:0]        ram_rdata,
   output logic [4:0]        cursor_x,
   output logic [4:0]        cursor_y,
   output logic              busy
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_PUT       = 3'd1;
   localparam logic [2:0] S_CLEAR     = 3'd2;
`ifdef TEXT_WRITER_SCROLL_EN
   localparam logic [2:0] S_SCR_RD    = 3'd3;
   localparam logic [2:0] S_SCR_WR    = 3'd4;
   localparam logic [2:0] S_SCR_BLANK = 3'd5;
   localparam logic [ADDR_W-1:0] SCR_LAST = ADDR_W'((ROWS-1)*COLS-1);
`endif

   localparam logic [4:0]        X_MAX     = 5'(COLS-1);
   localparam logic [4:0]        Y_MAX     = 5'(ROWS-1);
   localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(ROWS*COLS-1);

   logic [2:0]        state_q, state_d;
   logic [4:0]        x_q, x_d;
   logic [4:0]        y_q, y_d;
   logic              in_ready_q, in_ready_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [7:0]        ram_wdata_q, ram_wdata_d;
   logic              ram_we_q, ram_we_d;
   logic              busy_q, busy_d;
   logic              accept;
   logic              take_nl;
   logic              printable;
`ifdef TEXT_WRITER_SCROLL_EN
   logic [ADDR_W-1:0] scr_cnt_q, scr_cnt_d;
`endif

   assign accept    = in_valid && in_ready_q;
   assign printable = (in_data >= 8'h20) && (in_data != 8'h7F);

   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      ram_we_d    = 1'b0;
      busy_d      = busy_q;
      take_nl     = 1'b0;
`ifdef TEXT_WRITER_SCROLL_EN
      scr_cnt_d   = scr_cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (printable) begin
                  state_d     = S_PUT;
                  ram_we_d    = 1'b1;
                  ram_addr_d  = ADDR_W'({y_q, x_q});
                  ram_wdata_d = in_data;
               end else begin
                  case (in_data)
                     8'h0D: x_d = 5'd0;
                     8'h0A: take_nl = 1'b1;
                     8'h08: begin
                        if (x_q != 5'd0) begin
                           x_d = x_q - 5'd1;
                        end else if (y_q != 5'd0) begin
                           x_d = X_MAX;
                           y_d = y_q - 5'd1;
                        end
                     end
                     8'h0C: begin
                        state_d     = S_CLEAR;
                        busy_d      = 1'b1;
                        ram_we_d    = 1'b1;
                        ram_addr_d  = '0;
                        ram_wdata_d = CLEAR_CHAR;
                     end
                     default: ;
                  endcase
               end
            end
         end
         S_PUT: begin
            state_d = S_IDLE;
            if (x_q == X_MAX) begin
               x_d     = 5'd0;
               take_nl = 1'b1;
            end else begin
               x_d = x_q + 5'd1;
            end
         end
         S_CLEAR: begin
            if (ram_addr_q == LAST_CELL) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
               x_d     = 5'd0;
               y_d     = 5'd0;
            end else begin
               ram_we_d   = 1'b1;
               ram_addr_d = ram_addr_q + 1'b1;
            end
         end
`ifdef TEXT_WRITER_SCROLL_EN
         S_SCR_RD: begin
            state_d    = S_SCR_WR;
            ram_addr_d = scr_cnt_q;
            ram_we_d   = 1'b1;
         end
         S_SCR_WR: begin
            if (scr_cnt_q == SCR_LAST) begin
               state_d     = S_SCR_BLANK;
               ram_addr_d  = SCR_LAST + 1'b1;
               ram_we_d    = 1'b1;
               ram_wdata_d = CLEAR_CHAR;
            end else begin
               state_d    = S_SCR_RD;
               scr_cnt_d  = scr_cnt_q + 1'b1;
               ram_addr_d = scr_cnt_q + 1'b1 + ADDR_W'(COLS);
            end
         end
         S_SCR_BLANK: begin
            if (ram_addr_q == LAST_CELL) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end else begin
               ram_we_d   = 1'b1;
               ram_addr_d = ram_addr_q + 1'b1;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase

      // New line: step down, or act on the bottom row.
      if (take_nl) begin
         if (y_q != Y_MAX) begin
            y_d = y_q + 5'd1;
         end else begin
`ifdef TEXT_WRITER_SCROLL_EN
            state_d    = S_SCR_RD;
            busy_d     = 1'b1;
            ram_we_d   = 1'b0;
            ram_addr_d = ADDR_W'(COLS);
            scr_cnt_d  = '0;
`else
            y_d = 5'd0;
`endif
         end
      end

      in_ready_d = (state_d == S_IDLE) && !(state_q == S_IDLE && accept);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         x_q         <= 5'd0;
         y_q         <= 5'd0;
         in_ready_q  <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= 8'h00;
         ram_we_q    <= 1'b0;
         busy_q      <= 1'b0;
`ifdef TEXT_WRITER_SCROLL_EN
         scr_cnt_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         in_ready_q  <= in_ready_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         ram_we_q    <= ram_we_d;
         busy_q      <= busy_d;
`ifdef TEXT_WRITER_SCROLL_EN
         scr_cnt_q   <= scr_cnt_d;
`endif
      end
   end

`ifdef TEXT_WRITER_SCROLL_EN
   // The read data arrives during SCR_WR, so it bypasses the write-data register.
   assign ram_wdata = (state_q == S_SCR_WR) ? ram_rdata : ram_wdata_q;
`else
   logic unused_rdata;
   assign unused_rdata = ^ram_rdata;
   assign ram_wdata    = ram_wdata_q;
`endif

   assign in_ready = in_ready_q;
   assign ram_addr = ram_addr_q;
   assign ram_we   = ram_we_q;
   assign busy     = busy_q;
   assign cursor_x = x_q;
   assign cursor_y = y_q;

endmodule
